dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the byte-lane data memory (6-bit word index, 2-bit lane offset, sw/sh/sb strobes, async read).
//  Port 0 = core load/store unit, port 1 = loader/debug master. Accepts byte-addressed load/store requests.
//  Drives the memory's lane controls, checks alignment, and returns sign/zero-extended load data with fixed latency.
//  Throughput is one access per cycle.
// PARAMETERS
//  ADR_W      6  word-index width; byte address width is ADR_W+2
//  MAX_STREAK 4  max consecutive port-0 grants while port 1 is waiting (1..15)
// PORTS
//  clk            in   1        single clock, rising edge
//  rst            in   1        reset, asynchronous, active-high
//  pN_req         in   1        request (N=0,1); held with all fields stable until pN_gnt
//  pN_we          in   1        1=store, 0=load
//  pN_size        in   2        00 byte, 01 half, 10 word, 11 illegal
//  pN_uns         in   1        load zero-extend (1) / sign-extend (0)
//  pN_addr        in   ADR_W+2  byte address
//  pN_wdata       in   32       store data, right-justified
//  pN_gnt         out  1        combinational accept pulse; command taken this cycle
//  pN_rvalid      out  1        one-cycle response strobe, exactly 2 cycles after pN_gnt
//  pN_rdata       out  32       extended load data; 0 for stores and errors
//  pN_err         out  1        misaligned/illegal; qualified by pN_rvalid
//  mem_adr        out  ADR_W    word index = addr[ADR_W+1:2]
//  mem_a          out  2        lane select
//  mem_we/sw/sh/sb out 1 each   write enable and size strobes to memory
//  mem_wd         out  32       store data, right-justified
//  mem_rd         in   32       async read data of mem_adr
// BEHAVIOUR
//  Reset values: all outputs 0; issue-valid, response regs and streak counter cleared.
//  Arbitration (grant stage, comb.): p0 wins by default.
//   p1 wins if p1_req && (!p0_req || streak==MAX_STREAK).
//   Exactly one gnt per cycle at most; no gnt while rst high.
//  Streak counter: +1 on each p0 grant while p1_req=1 (saturating at MAX_STREAK).
//   Cleared on p1 grant, or on any cycle with p1_req=0.
//  Grant loads the issue register (port id, we, size, uns, addr, wdata, err). Issue stage = cycle after gnt:
//   mem_adr/mem_a/strobes/mem_wd driven from the issue register.
//   mem_we=1 only if issue valid && we && !err.
//   Strobes when idle or err: all 0, mem_adr=0, mem_a=0.
//   Lane map: word -> sw=1, mem_a=00.
//   Half -> sh=1, mem_a = addr[1] ? 2'b01 : 2'b00; memory decodes 01 as upper half.
//   Byte -> sb=1, mem_a=addr[1:0].
//  err: size=11; half with addr[0]=1; word with addr[1:0]!=0. Erroneous stores never write.
//  Response stage: at end of issue cycle, rdata/err/rvalid registered for the issuing port only.
//   Load: byte lane addr[1:0] or half addr[1], extended per uns.
//   Word: mem_rd unchanged.
//  Latency: gnt @N -> memory access @N+1 -> rvalid @N+2. Back-to-back grants allowed.
//   A load issued the cycle after a store to the same word sees the new data (write at N+1 edge, read at N+2).
//  Both ports requesting with streak<MAX_STREAK: p0 granted, p1_gnt=0, p1 must keep req high.
//  rst asserted mid-operation: issue valid and response cleared immediately (async).
//   mem_we drops at once; in-flight access discarded, no rvalid. First gnt possible the cycle after rst deasserts.
// STRUCTURE
//  Package dmem_pkg: SIZE_B/SIZE_H/SIZE_W/SIZE_X localparams.
//   Also: lane-select constants, issue-record field widths, function misaligned(size, addr[1:0]).
//  Sub-module dmem_load_align: comb. lane extraction + sign/zero extension (size, uns, offset, mem_rd -> rdata).
//  Top holds arbiter, streak counter, issue register, response registers.
// TESTING
//  Reset: rst=1 mid-store (gnt seen) -> mem_we=0 same cycle; no rvalid; outputs 0 after release.
//  p0 sw addr 0x08 data 0x9F5D4A6E -> mem_adr=2, sw=1, mem_a=00, we=1 @N+1.
//   Then lw 0x08 -> rdata 0x9F5D4A6E @rvalid.
//  p0 sb 0x0B data 0x80 then lb/lbu 0x0B -> mem_a=11, WE lane3.
//   Results: lb rdata 0xFFFFFF80, lbu rdata 0x00000080.
//  p1 sh 0x06 data 0xBEEF -> sh=1, mem_a=01.
//   Then lh 0x06 -> 0xFFFFBEEF; lh 0x07 -> err=1, rdata 0, no write.
//  p0 and p1 both request continuously, MAX_STREAK=4 -> grant pattern 0,0,0,0,1,0,0,0,0,1.
//   rvalid always 2 cycles after each gnt, never both ports in one cycle.
//  sw 0x0A, size=11 -> err=1, mem_we never asserted; memory word unchanged on readback.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, lane selects,
// issue-record layout and the alignment check used at grant time.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  // Lane selects on mem_a; for halfwords the memory reads LANE_HI as the upper half.
  localparam logic [1:0] LANE_0  = 2'b00;
  localparam logic [1:0] LANE_LO = 2'b00;
  localparam logic [1:0] LANE_HI = 2'b01;

  localparam int PORT_BITS   = 1;
  localparam int SIZE_BITS   = 2;
  localparam int DATA_W      = 32;
  localparam int STREAK_W    = 4;

  typedef struct packed {
    logic [PORT_BITS-1:0] port;
    logic                 we;
    logic [SIZE_BITS-1:0] size;
    logic                 uns;
    logic                 err;
  } iss_ctrl_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = off[0];
      SIZE_W:  bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-path lane extraction: picks the addressed byte/half out of the memory
// word and sign- or zero-extends it to 32 bits.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [DATA_W-1:0] rdata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every comb output gets a default before the case, so no path can infer a latch.
  always_comb begin
    byte_v = 8'h00;
    half_v = offset[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (offset)
      2'b00:   byte_v = mem_rd[7:0];
      2'b01:   byte_v = mem_rd[15:8];
      2'b10:   byte_v = mem_rd[23:16];
      default: byte_v = mem_rd[31:24];
    endcase
  end

  always_comb begin
    rdata = mem_rd;
    case (size)
      SIZE_B:  rdata = {{24{~uns & byte_v[7]}}, byte_v};
      SIZE_H:  rdata = {{16{~uns & half_v[15]}}, half_v};
      default: rdata = mem_rd;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the byte-lane data memory: grant, one issue
// cycle driving the memory, one registered response cycle (fixed 2-cycle latency).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADR_W      = 6,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [1:0]        p0_size,
  input  logic              p0_uns,
  input  logic [ADR_W+1:0]  p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [1:0]        p1_size,
  input  logic              p1_uns,
  input  logic [ADR_W+1:0]  p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,

  output logic [ADR_W-1:0]  mem_adr,
  output logic [1:0]        mem_a,
  output logic              mem_we,
  output logic              mem_sw,
  output logic              mem_sh,
  output logic              mem_sb,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  logic [STREAK_W-1:0] streak;
  logic                p1_win;
  logic                any_gnt;

  logic                iss_valid;
  iss_ctrl_t           iss;
  logic [ADR_W+1:0]    iss_addr;
  logic [31:0]         iss_wdata;
  logic                iss_active;

  logic [31:0]         aligned;
  logic [31:0]         resp_data;

  // Port 0 has priority unless port 1 has watched MAX_STREAK port-0 grants go by.
  assign p1_win  = p1_req && (!p0_req || streak == STREAK_W'(MAX_STREAK));
  assign p1_gnt  = !rst && p1_win;
  assign p0_gnt  = !rst && p0_req && !p1_win;
  assign any_gnt = p0_gnt || p1_gnt;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (!p1_req || p1_gnt) begin
      streak <= '0;
    end else if (p0_gnt && streak != STREAK_W'(MAX_STREAK)) begin
      streak <= streak + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss       <= '0;
      iss_addr  <= '0;
      iss_wdata <= '0;
    end else begin
      iss_valid <= any_gnt;
      if (any_gnt) begin
        iss.port  <= p1_gnt;
        iss.we    <= p1_gnt ? p1_we   : p0_we;
        iss.size  <= p1_gnt ? p1_size : p0_size;
        iss.uns   <= p1_gnt ? p1_uns  : p0_uns;
        iss.err   <= p1_gnt ? misaligned(p1_size, p1_addr[1:0])
                            : misaligned(p0_size, p0_addr[1:0]);
        iss_addr  <= p1_gnt ? p1_addr  : p0_addr;
        iss_wdata <= p1_gnt ? p1_wdata : p0_wdata;
      end
    end
  end

  // Issue stage: memory controls come straight from the issue register; idle or erroneous drives all zero.
  assign iss_active = iss_valid && !iss.err;

  always_comb begin
    mem_adr = '0;
    mem_a   = LANE_0;
    mem_we  = 1'b0;
    mem_sw  = 1'b0;
    mem_sh  = 1'b0;
    mem_sb  = 1'b0;
    mem_wd  = '0;
    if (iss_active) begin
      mem_adr = iss_addr[ADR_W+1:2];
      mem_we  = iss.we;
      mem_wd  = iss.we ? iss_wdata : 32'h0;
      case (iss.size)
        SIZE_W: begin
          mem_sw = 1'b1;
          mem_a  = LANE_0;
        end
        SIZE_H: begin
          mem_sh = 1'b1;
          mem_a  = iss_addr[1] ? LANE_HI : LANE_LO;
        end
        SIZE_B: begin
          mem_sb = 1'b1;
          mem_a  = iss_addr[1:0];
        end
        default: mem_a = LANE_0;
      endcase
    end
  end

  dmem_load_align u_align (
    .size   (iss.size),
    .uns    (iss.uns),
    .offset (iss_addr[1:0]),
    .mem_rd (mem_rd),
    .rdata  (aligned)
  );

  assign resp_data = (iss.we || iss.err) ? 32'h0 : aligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p0_err    <= 1'b0;
      p1_rvalid <= 1'b0;
      p1_rdata  <= '0;
      p1_err    <= 1'b0;
    end else begin
      p0_rvalid <= iss_valid && !iss.port;
      p1_rvalid <= iss_valid &&  iss.port;
      if (iss_valid && !iss.port) begin
        p0_rdata <= resp_data;
        p0_err   <= iss.err;
      end
      if (iss_valid && iss.port) begin
        p1_rdata <= resp_data;
        p1_err   <= iss.err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: byte-lane memory model, vector table for
// single accesses, and hand sequences for reset, back-to-back and starvation.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int ADR_W = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_uns, p1_req, p1_we, p1_uns;
  logic [1:0]  p0_size, p1_size;
  logic [7:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [5:0]  mem_adr;
  logic [1:0]  mem_a;
  logic        mem_we, mem_sw, mem_sh, mem_sb;
  logic [31:0] mem_wd, mem_rd;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.ADR_W(ADR_W), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_uns(p0_uns),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_uns(p1_uns),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_adr(mem_adr), .mem_a(mem_a), .mem_we(mem_we), .mem_sw(mem_sw),
    .mem_sh(mem_sh), .mem_sb(mem_sb), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Byte-lane memory: synchronous write, asynchronous read.
  logic [31:0] mem [64] = '{default: 32'h0};
  assign mem_rd = mem[mem_adr];

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_sw) mem[mem_adr] <= mem_wd;
      else if (mem_sh) begin
        if (mem_a == 2'b01) mem[mem_adr][31:16] <= mem_wd[15:0];
        else                mem[mem_adr][15:0]  <= mem_wd[15:0];
      end else if (mem_sb) mem[mem_adr][8*mem_a +: 8] <= mem_wd[7:0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          port;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [5:0]  e_adr;
    logic [1:0]  e_a;
    logic        e_we;
    logic [2:0]  e_str;   // {sw, sh, sb}
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs [16];

  task automatic drive(input bit port, input logic req, input logic we, input logic [1:0] size,
                       input logic uns, input logic [7:0] addr, input logic [31:0] wdata);
    if (port) begin
      p1_req = req; p1_we = we; p1_size = size; p1_uns = uns; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = req; p0_we = we; p0_size = size; p0_uns = uns; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit got;
    int n;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    drive(v.port, 1'b1, v.we, v.size, v.uns, v.addr, v.wdata);
    got = 1'b0;
    n   = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (v.port ? p1_gnt : p0_gnt) got = 1'b1;
      else n++;
    end
    check({tag, " gnt"}, 32'(got), 32'd1);
    check({tag, " other_gnt"}, 32'(v.port ? p0_gnt : p1_gnt), 32'd0);
    @(posedge clk); #1;
    drive(v.port, 1'b0, v.we, v.size, v.uns, v.addr, v.wdata);
    @(negedge clk);
    check({tag, " mem_adr"}, 32'(mem_adr), 32'(v.e_adr));
    check({tag, " mem_a"},   32'(mem_a),   32'(v.e_a));
    check({tag, " mem_we"},  32'(mem_we),  32'(v.e_we));
    check({tag, " strobes"}, 32'({mem_sw, mem_sh, mem_sb}), 32'(v.e_str));
    @(negedge clk);
    check({tag, " rvalid"}, 32'({p1_rvalid, p0_rvalid}), v.port ? 32'd2 : 32'd1);
    check({tag, " rdata"},  v.port ? p1_rdata : p0_rdata, v.e_rdata);
    check({tag, " err"},    32'(v.port ? p1_err : p0_err), 32'(v.e_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pat [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    int hist [12];
    int g;

    //            port we  size    uns addr   wdata         adr a      we  str     rdata         err
    vecs[0]  = '{0, 1, SIZE_W, 0, 8'h08, 32'h9F5D4A6E, 6'd2, 2'b00, 1, 3'b100, 32'h0,        0};
    vecs[1]  = '{0, 0, SIZE_W, 0, 8'h08, 32'h0,        6'd2, 2'b00, 0, 3'b100, 32'h9F5D4A6E, 0};
    vecs[2]  = '{0, 1, SIZE_B, 0, 8'h0B, 32'h00000080, 6'd2, 2'b11, 1, 3'b001, 32'h0,        0};
    vecs[3]  = '{0, 0, SIZE_B, 0, 8'h0B, 32'h0,        6'd2, 2'b11, 0, 3'b001, 32'hFFFFFF80, 0};
    vecs[4]  = '{0, 0, SIZE_B, 1, 8'h0B, 32'h0,        6'd2, 2'b11, 0, 3'b001, 32'h00000080, 0};
    vecs[5]  = '{1, 1, SIZE_H, 0, 8'h06, 32'h0000BEEF, 6'd1, 2'b01, 1, 3'b010, 32'h0,        0};
    vecs[6]  = '{1, 0, SIZE_H, 0, 8'h06, 32'h0,        6'd1, 2'b01, 0, 3'b010, 32'hFFFFBEEF, 0};
    vecs[7]  = '{1, 0, SIZE_H, 0, 8'h07, 32'h0,        6'd0, 2'b00, 0, 3'b000, 32'h0,        1};
    vecs[8]  = '{0, 1, SIZE_X, 0, 8'h0A, 32'h12345678, 6'd0, 2'b00, 0, 3'b000, 32'h0,        1};
    vecs[9]  = '{0, 0, SIZE_W, 0, 8'h08, 32'h0,        6'd2, 2'b00, 0, 3'b100, 32'h805D4A6E, 0};
    vecs[10] = '{0, 0, SIZE_H, 1, 8'h0A, 32'h0,        6'd2, 2'b01, 0, 3'b010, 32'h0000805D, 0};
    vecs[11] = '{0, 0, SIZE_H, 0, 8'h08, 32'h0,        6'd2, 2'b00, 0, 3'b010, 32'h00004A6E, 0};
    vecs[12] = '{1, 0, SIZE_B, 0, 8'h09, 32'h0,        6'd2, 2'b01, 0, 3'b001, 32'h0000004A, 0};
    vecs[13] = '{0, 0, SIZE_W, 0, 8'h06, 32'h0,        6'd0, 2'b00, 0, 3'b000, 32'h0,        1};
    vecs[14] = '{1, 0, SIZE_W, 0, 8'h04, 32'h0,        6'd1, 2'b00, 0, 3'b100, 32'hBEEF0000, 0};
    vecs[15] = '{0, 0, SIZE_B, 1, 8'h0A, 32'h0,        6'd2, 2'b10, 0, 3'b001, 32'h0000005D, 0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, SIZE_B, 1'b0, 8'h00, 32'h0);
    drive(1'b1, 1'b0, 1'b0, SIZE_B, 1'b0, 8'h00, 32'h0);
    repeat (2) @(negedge clk);
    check("reset gnt",    32'({p0_gnt, p1_gnt}), 32'd0);
    check("reset mem",    32'({mem_we, mem_sw, mem_sh, mem_sb, mem_a}), 32'd0);
    check("reset adr",    32'(mem_adr), 32'd0);
    check("reset wd",     mem_wd, 32'd0);
    check("reset rvalid", 32'({p0_rvalid, p1_rvalid, p0_err, p1_err}), 32'd0);
    check("reset rdata",  p0_rdata | p1_rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);
    check("size11 store left word intact", mem[2], 32'h805D4A6E);
    check("misaligned lh left word intact", mem[1], 32'hBEEF0000);

    // Store then load to the same word on consecutive grants.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, SIZE_W, 1'b0, 8'h10, 32'hCAFEF00D);
    @(negedge clk);
    check("b2b store gnt", 32'(p0_gnt), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, SIZE_W, 1'b0, 8'h10, 32'h0);
    @(negedge clk);
    check("b2b load gnt", 32'(p0_gnt), 32'd1);
    check("b2b store we", 32'({mem_we, mem_sw}), 32'd3);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, SIZE_W, 1'b0, 8'h10, 32'h0);
    @(negedge clk);
    check("b2b store rvalid", 32'(p0_rvalid), 32'd1);
    check("b2b load issue", 32'({mem_we, mem_adr}), 32'd4);
    @(negedge clk);
    check("b2b load rvalid", 32'(p0_rvalid), 32'd1);
    check("b2b load rdata", p0_rdata, 32'hCAFEF00D);

    // Both ports request continuously: port 1 gets every fifth slot.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, SIZE_W, 1'b0, 8'h08, 32'h0);
    drive(1'b1, 1'b1, 1'b0, SIZE_W, 1'b0, 8'h04, 32'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      g = p0_gnt ? 1 : (p1_gnt ? 2 : 0);
      hist[i] = g;
      check($sformatf("streak both_gnt c%0d", i), 32'(p0_gnt & p1_gnt), 32'd0);
      check($sformatf("streak gnt c%0d", i), 32'(g), (i < 10) ? 32'(pat[i]) : 32'd0);
      if (i >= 2) begin
        check($sformatf("streak rvalid c%0d", i), 32'({p1_rvalid, p0_rvalid}), 32'(pat[i-2]));
        if (p0_rvalid) check($sformatf("streak p0 rdata c%0d", i), p0_rdata, 32'h805D4A6E);
        if (p1_rvalid) check($sformatf("streak p1 rdata c%0d", i), p1_rdata, 32'hBEEF0000);
      end
      if (i == 9) begin
        @(posedge clk); #1;
        p0_req = 1'b0;
        p1_req = 1'b0;
      end
    end

    // Reset asserted during the issue cycle of a store.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, SIZE_W, 1'b0, 8'h20, 32'h11111111);
    @(negedge clk);
    check("rst store gnt", 32'(p0_gnt), 32'd1);
    @(posedge clk); #1;
    p0_req = 1'b0;
    p1_req = 1'b1;
    #2;
    check("rst pre mem_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("rst mem_we drop", 32'(mem_we), 32'd0);
    check("rst no gnt", 32'({p0_gnt, p1_gnt}), 32'd0);
    @(negedge clk);
    check("rst no rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
    @(posedge clk); #1;
    p1_req = 1'b0;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post-rst rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
      check("post-rst mem", 32'({mem_we, mem_sw, mem_sh, mem_sb, mem_a, mem_adr}), 32'd0);
      check("post-rst rdata", p0_rdata | p1_rdata, 32'd0);
    end
    check("rst store discarded", mem[8], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
